// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-cycle byte strobe
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   rx         in   1  asynchronous serial line, idle high
//   d_out      out  8  last received byte, LSB = first data bit on the line
//   valid      out  1  one-cycle pulse when d_out holds a new byte
//   frame_err  out  1  one-cycle pulse on a low stop bit (only with UART_RX_FRAME_ERR_EN)
//
// Build option: define UART_RX_FRAME_ERR_EN to check the stop bit and add frame_err.
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] d_out,
  output logic       valid
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_HALF = TW'(HALF_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      d_out_q, d_out_d;
  logic            valid_q, valid_d;
  logic            rx_meta_q, rx_s_q;
`ifdef UART_RX_FRAME_ERR_EN
  logic            frame_err_q, frame_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    d_out_d   = d_out_q;
    valid_d   = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end

      // Re-check the line at the middle of the start bit; a line that has
      // gone high again was only a glitch.
      START: begin
        if (timer_q == TIMER_HALF) begin
          timer_d = '0;
          if (!rx_s_q) begin
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // Timer was cleared at mid-start-bit, so every wrap lands mid-bit.
      DATA: begin
        if (timer_q == TIMER_LAST) begin
          timer_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // Leave at mid-stop-bit so a start bit right after the stop bit is seen.
      STOP: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s_q) begin
            d_out_d = shift_q;
            valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
`else
          d_out_d = shift_q;
          valid_d = 1'b1;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      d_out_q   <= 8'h00;
      valid_q   <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      d_out_q   <= d_out_d;
      valid_q   <= valid_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
`ifdef UART_RX_FRAME_ERR_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign d_out = d_out_q;
  assign valid = valid_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed table-driven bench for uart_rx
module tb_uart_rx;

  // Baud chosen so one bit is 16 clocks, keeping the run short.
  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 3125000;
  localparam int CPB      = 16;
  localparam int HALF     = 8;
  localparam int LAT      = 2 + HALF + 9 * CPB + 1;
`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] d_out;
  logic       valid;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  always #10 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .d_out (d_out),
    .valid (valid)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int miss = 0;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         fe_cyc[$];
  logic       prev_valid = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [7:0] prev_dout  = 8'h00;

  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(d_out);
      vecs++;
      if (prev_valid) begin
        miss++;
        $display("FAIL valid_width: valid high two cycles in a row at cycle %0d", cyc);
      end
    end
    if (d_out !== prev_dout && !valid && !prev_rst) begin
      vecs++;
      miss++;
      $display("FAIL dout_hold: d_out changed %02h -> %02h without valid at cycle %0d",
               prev_dout, d_out, cyc);
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err) fe_cyc.push_back(cyc);
`endif
    prev_valid = valid;
    prev_rst   = rst;
    prev_dout  = d_out;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int diff);
    vecs++;
    if (diff < LAT - 1 || diff > LAT + 1) begin
      miss++;
      $display("FAIL %s: latency got %0d expected %0d (+/-1)", name, diff, LAT);
    end
  endtask

  // Drives one frame; rst is pulsed mid-way through data bit rst_bit (-1 = never).
  task automatic send_frame(input logic [7:0] data, input logic stop, input int rst_bit,
                            output int start);
    start = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == rst_bit) begin
        tick(HALF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(CPB - HALF - 1);
      end else begin
        tick(CPB);
      end
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap_bits;
    logic       exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[7];
  int   starts[7];

  initial begin
    int st;
    int idx;
    int n_exp;

    tbl[0] = '{8'h46, 1'b1, 0, 1'b1, 8'h46};
    tbl[1] = '{8'h50, 1'b1, 0, 1'b1, 8'h50};
    tbl[2] = '{8'h47, 1'b1, 0, 1'b1, 8'h47};
    tbl[3] = '{8'h41, 1'b1, 4, 1'b1, 8'h41};
    tbl[4] = '{8'h55, 1'b0, 4, !FE_EN, FE_EN ? 8'h41 : 8'h55};
    tbl[5] = '{8'h00, 1'b1, 0, 1'b1, 8'h00};
    tbl[6] = '{8'hFF, 1'b1, 2, 1'b1, 8'hFF};

    // Reset and idle line
    rst = 1'b1;
    rx  = 1'b1;
    tick(5);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_dout", {24'd0, d_out}, 32'h00);
`ifdef UART_RX_FRAME_ERR_EN
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
`endif
    rst = 1'b0;
    tick(20 * CPB);
    check("idle_no_valid", v_cyc.size(), 0);
    check("idle_dout", {24'd0, d_out}, 32'h00);

    // Table of frames
    v_cyc.delete();
    v_dat.delete();
    fe_cyc.delete();
    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, -1, st);
      starts[i] = st;
      if (tbl[i].gap_bits > 0) begin
        tick(tbl[i].gap_bits * CPB);
        check($sformatf("tbl%0d_dout_after_gap", i), {24'd0, d_out}, {24'd0, tbl[i].exp_dout});
      end
    end
    tick(2 * CPB);

    n_exp = 0;
    for (int i = 0; i < 7; i++) if (tbl[i].exp_valid) n_exp++;
    check("tbl_valid_count", v_cyc.size(), n_exp);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].exp_valid) begin
        if (idx < v_cyc.size()) begin
          check($sformatf("tbl%0d_data", i), {24'd0, v_dat[idx]}, {24'd0, tbl[i].exp_dout});
          check_lat($sformatf("tbl%0d_latency", i), v_cyc[idx] - starts[i]);
        end
        idx++;
      end
    end
    check("tbl_final_dout", {24'd0, d_out}, 32'hFF);
`ifdef UART_RX_FRAME_ERR_EN
    check("fe_count", fe_cyc.size(), 1);
    if (fe_cyc.size() > 0) check_lat("fe_latency", fe_cyc[0] - starts[4]);
`endif

    // Short low glitch from idle, then a real frame
    v_cyc.delete();
    v_dat.delete();
    rx = 1'b0;
    tick(HALF - 3);
    rx = 1'b1;
    tick(2 * CPB);
    check("glitch_no_valid", v_cyc.size(), 0);
    send_frame(8'hA5, 1'b1, -1, st);
    tick(2 * CPB);
    check("after_glitch_count", v_cyc.size(), 1);
    if (v_cyc.size() > 0) begin
      check("after_glitch_data", {24'd0, v_dat[0]}, 32'hA5);
      check_lat("after_glitch_latency", v_cyc[0] - st);
    end

    // Reset during data bit 4 aborts the frame
    v_cyc.delete();
    v_dat.delete();
    send_frame(8'hFF, 1'b1, 4, st);
    tick(2 * CPB);
    check("rst_mid_no_valid", v_cyc.size(), 0);
    check("rst_mid_dout", {24'd0, d_out}, 32'h00);
    send_frame(8'h3C, 1'b1, -1, st);
    tick(2 * CPB);
    check("after_rst_count", v_cyc.size(), 1);
    if (v_cyc.size() > 0) check("after_rst_data", {24'd0, v_dat[0]}, 32'h3C);
    check("after_rst_dout", {24'd0, d_out}, 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
